// File: rtl/qrd_sched_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : qrd_sched_if                                               |
// | Description : Bus bundle for qrd_sched: H input stream, R/QH output      |
// |               stream and the skewed feed/capture lanes of the QRD core.  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface qrd_sched_if #(
   parameter int W = 14
);
   // H element input stream
   logic         s_valid;
   logic         s_ready;
   logic [W-1:0] s_data_r;
   logic [W-1:0] s_data_i;

   // R / QH result output stream
   logic         m_valid;
   logic         m_ready;
   logic [W-1:0] m_data_r;
   logic [W-1:0] m_data_i;
   logic         m_is_qh;
   logic         m_last;

   // skewed row feed towards the systolic core
   logic [W-1:0] core_row_in_1_r, core_row_in_1_i;
   logic [W-1:0] core_row_in_2_r, core_row_in_2_i;
   logic [W-1:0] core_row_in_3_r, core_row_in_3_i;
   logic [W-1:0] core_row_in_4_r, core_row_in_4_i;
   logic         core_row_in_1_f, core_row_in_2_f, core_row_in_3_f;
   logic         core_in_ready;

   // row outputs coming back from the core
   logic         core_out_valid;
   logic [W-1:0] core_row_out_1_r, core_row_out_1_i;
   logic [W-1:0] core_row_out_2_r, core_row_out_2_i;
   logic [W-1:0] core_row_out_3_r, core_row_out_3_i;
   logic [W-1:0] core_row_out_4_r, core_row_out_4_i;

   // scheduler side
   modport master (
      input  s_valid, s_data_r, s_data_i, m_ready, core_in_ready, core_out_valid,
      input  core_row_out_1_r, core_row_out_1_i, core_row_out_2_r, core_row_out_2_i,
      input  core_row_out_3_r, core_row_out_3_i, core_row_out_4_r, core_row_out_4_i,
      output s_ready, m_valid, m_data_r, m_data_i, m_is_qh, m_last,
      output core_row_in_1_r, core_row_in_1_i, core_row_in_2_r, core_row_in_2_i,
      output core_row_in_3_r, core_row_in_3_i, core_row_in_4_r, core_row_in_4_i,
      output core_row_in_1_f, core_row_in_2_f, core_row_in_3_f
   );

   // environment side (source, sink and core)
   modport slave (
      output s_valid, s_data_r, s_data_i, m_ready, core_in_ready, core_out_valid,
      output core_row_out_1_r, core_row_out_1_i, core_row_out_2_r, core_row_out_2_i,
      output core_row_out_3_r, core_row_out_3_i, core_row_out_4_r, core_row_out_4_i,
      input  s_ready, m_valid, m_data_r, m_data_i, m_is_qh, m_last,
      input  core_row_in_1_r, core_row_in_1_i, core_row_in_2_r, core_row_in_2_i,
      input  core_row_in_3_r, core_row_in_3_i, core_row_in_4_r, core_row_in_4_i,
      input  core_row_in_1_f, core_row_in_2_f, core_row_in_3_f
   );
endinterface
`default_nettype wire

// File: rtl/qrd_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : qrd_sched                                                  |
// | Description : Buffers a 4x4 complex H, feeds [H | I] skewed into the QRD |
// |               systolic core, captures R and QH and streams them out      |
// |               row-major.                                                 |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module qrd_sched #(
   parameter int W           = 14,
   parameter int ONE         = 1024,
   parameter int STALL_LIMIT = 1000
) (
   input  logic        clk,
   input  logic        rst,
   qrd_sched_if.master bus,
   output logic        busy,
   output logic        err
);
   localparam int SCW = $clog2(STALL_LIMIT + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, FEED = 2'd2, DRAIN = 2'd3} state_t;

   state_t           state;
   logic [3:0]       e;          // load element index
   logic [4:0]       s;          // feed step
   logic [4:0]       o;          // output element index
   logic [SCW-1:0]   stall_cnt;
   logic             in_rdy;
   logic             out_vld;

   logic [W-1:0]     h_r [16];
   logic [W-1:0]     h_i [16];
   logic [W-1:0]     r_r [16];
   logic [W-1:0]     r_i [16];
   logic [W-1:0]     q_r [16];
   logic [W-1:0]     q_i [16];

   logic [W-1:0]     cout_r [4];
   logic [W-1:0]     cout_i [4];
   logic [W-1:0]     feed_r [4];
   logic [W-1:0]     feed_i [4];
   logic [4:0]       fj [4];     // column of A presented on each row this step
   logic [4:0]       rd [4];     // R column captured on each row (valid when < 4)
   logic [4:0]       qd [4];     // QH column captured on each row (valid when < 4)
   logic             cap_slot;
   logic [W-1:0]     out_r;
   logic [W-1:0]     out_i;

   assign cout_r[0] = bus.core_row_out_1_r;  assign cout_i[0] = bus.core_row_out_1_i;
   assign cout_r[1] = bus.core_row_out_2_r;  assign cout_i[1] = bus.core_row_out_2_i;
   assign cout_r[2] = bus.core_row_out_3_r;  assign cout_i[2] = bus.core_row_out_3_i;
   assign cout_r[3] = bus.core_row_out_4_r;  assign cout_i[3] = bus.core_row_out_4_i;

   // Skewed feed of [H | I]; row k lags row 0 by k steps and is zero outside FEED.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         fj[k]     = s - 5'(k);
         feed_r[k] = '0;
         feed_i[k] = '0;
         if (state == FEED && fj[k] < 5'd8) begin
            if (fj[k] < 5'd4) begin
               feed_r[k] = h_r[{2'(k), fj[k][1:0]}];
               feed_i[k] = h_i[{2'(k), fj[k][1:0]}];
            end else if (fj[k][1:0] == 2'(k)) begin
               feed_r[k] = W'(ONE);
            end
         end
      end
   end

   assign bus.core_row_in_1_r = feed_r[0];  assign bus.core_row_in_1_i = feed_i[0];
   assign bus.core_row_in_2_r = feed_r[1];  assign bus.core_row_in_2_i = feed_i[1];
   assign bus.core_row_in_3_r = feed_r[2];  assign bus.core_row_in_3_i = feed_i[2];
   assign bus.core_row_in_4_r = feed_r[3];  assign bus.core_row_in_4_i = feed_i[3];
   assign bus.core_row_in_1_f = (state == FEED) && (s == 5'd0);
   assign bus.core_row_in_2_f = (state == FEED) && (s == 5'd2);
   assign bus.core_row_in_3_f = (state == FEED) && (s == 5'd4);

   // Capture schedule: row k emits R col s-5-k, then QH col s-9-k (k zero-based).
   // Steps below the window wrap to large values, so a single "< 4" test suffices.
   always_comb begin
      cap_slot = 1'b0;
      for (int k = 0; k < 4; k++) begin
         rd[k]    = s - 5'(5 + k);
         qd[k]    = s - 5'(9 + k);
         cap_slot = cap_slot | (rd[k] < 5'd4) | (qd[k] < 5'd4);
      end
   end

   // H buffer write during LOAD.
   always_ff @(posedge clk) begin
      if (!rst && state == LOAD && bus.s_valid && in_rdy) begin
         h_r[e] <= bus.s_data_r;
         h_i[e] <= bus.s_data_i;
      end
   end

   // R / QH capture on each consumed step that carries valid core output.
   always_ff @(posedge clk) begin
      if (!rst && state == FEED && bus.core_in_ready && bus.core_out_valid) begin
         for (int k = 0; k < 4; k++) begin
            if (rd[k] < 5'd4) begin
               r_r[{2'(k), rd[k][1:0]}] <= cout_r[k];
               r_i[{2'(k), rd[k][1:0]}] <= cout_i[k];
            end
            if (qd[k] < 5'd4) begin
               q_r[{2'(k), qd[k][1:0]}] <= cout_r[k];
               q_i[{2'(k), qd[k][1:0]}] <= cout_i[k];
            end
         end
      end
   end

   // Sequencer: IDLE -> LOAD -> FEED -> DRAIN -> IDLE, with stall abort from FEED.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         e         <= '0;
         s         <= '0;
         o         <= '0;
         stall_cnt <= '0;
         in_rdy    <= 1'b0;
         out_vld   <= 1'b0;
         busy      <= 1'b0;
         err       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state  <= LOAD;
               e      <= '0;
               in_rdy <= 1'b1;
               busy   <= 1'b1;
               err    <= 1'b0;
            end
            LOAD: begin
               if (bus.s_valid && in_rdy) begin
                  if (e == 4'd15) begin
                     in_rdy    <= 1'b0;
                     state     <= FEED;
                     s         <= '0;
                     stall_cnt <= '0;
                  end else begin
                     e <= e + 4'd1;
                  end
               end
            end
            FEED: begin
               if (bus.core_in_ready) begin
                  stall_cnt <= '0;
                  if (cap_slot && !bus.core_out_valid) begin
                     err <= 1'b1;
                  end
                  if (s == 5'd21) begin
                     state   <= DRAIN;
                     o       <= '0;
                     out_vld <= 1'b1;
                  end else begin
                     s <= s + 5'd1;
                  end
               end else if (stall_cnt == SCW'(STALL_LIMIT - 1)) begin
                  err       <= 1'b1;
                  state     <= IDLE;
                  busy      <= 1'b0;
                  stall_cnt <= '0;
               end else begin
                  stall_cnt <= stall_cnt + 1'b1;
               end
            end
            DRAIN: begin
               if (bus.m_ready) begin
                  if (o == 5'd31) begin
                     state   <= IDLE;
                     out_vld <= 1'b0;
                     busy    <= 1'b0;
                     o       <= '0;
                  end else begin
                     o <= o + 5'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Output mux: R for o<16, QH afterwards; quiet outside DRAIN.
   always_comb begin
      out_r = '0;
      out_i = '0;
      if (state == DRAIN) begin
         out_r = o[4] ? q_r[o[3:0]] : r_r[o[3:0]];
         out_i = o[4] ? q_i[o[3:0]] : r_i[o[3:0]];
      end
   end

   assign bus.s_ready  = in_rdy;
   assign bus.m_valid  = out_vld;
   assign bus.m_data_r = out_r;
   assign bus.m_data_i = out_i;
   assign bus.m_is_qh  = (state == DRAIN) && o[4];
   assign bus.m_last   = (state == DRAIN) && (o == 5'd31);
endmodule
`default_nettype wire

// File: tb/tb_qrd_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_qrd_sched                                               |
// | Description : Directed self-checking bench for qrd_sched with a simple   |
// |               scheduled core model and source/sink drivers.              |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_qrd_sched;
   localparam int W = 14;

   logic clk;
   logic rst;
   logic busy;
   logic err;
   int   n_vec;
   int   n_bad;
   int   h_r [16];
   int   h_i [16];
   int   row1_tab [8]  = '{1, 2, 3, 4, 1024, 0, 0, 0};
   int   row4_tab [11] = '{0, 0, 0, 13, 14, 15, 16, 0, 0, 0, 1024};
   int   mpat [4]      = '{1, 0, 0, 1};
   int   cyc_used;

   qrd_sched_if #(.W(W)) bus ();

   qrd_sched #(.W(W), .ONE(1024), .STALL_LIMIT(1000)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy),
      .err  (err)
   );

   initial clk = 1'b0;
   // free-running 100 MHz clock
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int want);
      n_vec++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", tag, got, want);
      end
   endtask

   function automatic int sx(input logic [W-1:0] v);
      return int'($signed(v));
   endfunction

   function automatic int feed_val(input int k, input bit im);
      case (k)
         1:       return im ? sx(bus.core_row_in_1_i) : sx(bus.core_row_in_1_r);
         2:       return im ? sx(bus.core_row_in_2_i) : sx(bus.core_row_in_2_r);
         3:       return im ? sx(bus.core_row_in_3_i) : sx(bus.core_row_in_3_r);
         default: return im ? sx(bus.core_row_in_4_i) : sx(bus.core_row_in_4_r);
      endcase
   endfunction

   // expected feed for row k (1..4) at step st, from the loaded H plus identity
   function automatic int exp_feed(input int k, input int st, input bit im);
      int j;
      j = st - (k - 1);
      if (j < 0 || j >= 8) return 0;
      if (j < 4) return im ? h_i[(k-1)*4 + j] : h_r[(k-1)*4 + j];
      if (!im && (j - 4) == (k - 1)) return 1024;
      return 0;
   endfunction

   // core model: R[i][j]=100i+j, QH=-(100i+j) on the schedule, junk elsewhere
   function automatic int core_val(input int k, input int st);
      if (st >= 4 + k && st <= 7 + k)  return 100*(k-1) + (st - 4 - k);
      if (st >= 8 + k && st <= 11 + k) return -(100*(k-1) + (st - 8 - k));
      return 5000 + 10*k + st;
   endfunction

   task automatic set_core(input int st, input bit vld);
      bus.core_out_valid   = vld;
      bus.core_row_out_1_r = W'(core_val(1, st));  bus.core_row_out_1_i = W'(core_val(1, st) + 2000);
      bus.core_row_out_2_r = W'(core_val(2, st));  bus.core_row_out_2_i = W'(core_val(2, st) + 2000);
      bus.core_row_out_3_r = W'(core_val(3, st));  bus.core_row_out_3_i = W'(core_val(3, st) + 2000);
      bus.core_row_out_4_r = W'(core_val(4, st));  bus.core_row_out_4_i = W'(core_val(4, st) + 2000);
   endtask

   task automatic load_h(input int mode);
      int w;
      for (int e = 0; e < 16; e++) begin
         h_r[e]       = (mode == 0) ? e + 1 : 50 - 7*e;
         h_i[e]       = (mode == 0) ? 0 : 3*e + 1;
         bus.s_valid  = 1'b1;
         bus.s_data_r = W'(h_r[e]);
         bus.s_data_i = W'(h_i[e]);
         w = 0;
         while (!bus.s_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
         end
         chk($sformatf("s_ready_e%0d", e), int'(bus.s_ready), 1);
         @(posedge clk); #1;
      end
      bus.s_valid = 1'b0;
      chk("s_ready_after_load", int'(bus.s_ready), 0);
      chk("busy_in_feed", int'(busy), 1);
   endtask

   task automatic run_feed(input bit toggle, input int stop, input bit tab, input int drop,
                           output int cycles);
      int st;
      int cyc;
      st  = 0;
      cyc = 0;
      while (st < stop && cyc < 200) begin
         bus.core_in_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
         set_core(st, st != drop);
         for (int k = 1; k <= 4; k++) begin
            chk($sformatf("feed_r%0d_s%0d", k, st), feed_val(k, 1'b0), exp_feed(k, st, 1'b0));
            chk($sformatf("feed_i%0d_s%0d", k, st), feed_val(k, 1'b1), exp_feed(k, st, 1'b1));
         end
         chk($sformatf("f1_s%0d", st), int'(bus.core_row_in_1_f), int'(st == 0));
         chk($sformatf("f2_s%0d", st), int'(bus.core_row_in_2_f), int'(st == 2));
         chk($sformatf("f3_s%0d", st), int'(bus.core_row_in_3_f), int'(st == 4));
         if (tab && st < 8)  chk($sformatf("row1_tab_s%0d", st), feed_val(1, 1'b0), row1_tab[st]);
         if (tab && st < 11) chk($sformatf("row4_tab_s%0d", st), feed_val(4, 1'b0), row4_tab[st]);
         chk("m_valid_in_feed", int'(bus.m_valid), 0);
         @(posedge clk); #1;
         if (bus.core_in_ready) st++;
         cyc++;
      end
      bus.core_in_ready = 1'b0;
      bus.core_out_valid = 1'b0;
      chk("feed_steps", st, stop);
      cycles = cyc;
   endtask

   task automatic run_drain(input bit stall_pat, input int want_err);
      int o;
      int cyc;
      int want;
      o   = 0;
      cyc = 0;
      while (o < 32 && cyc < 300) begin
         bus.m_ready = stall_pat ? 1'(mpat[cyc % 4]) : 1'b1;
         want = (o < 16) ? 100*(o/4) + o%4 : -(100*((o-16)/4) + o%4);
         chk($sformatf("m_valid_o%0d", o), int'(bus.m_valid), 1);
         chk($sformatf("m_data_r_o%0d", o), sx(bus.m_data_r), want);
         chk($sformatf("m_data_i_o%0d", o), sx(bus.m_data_i), want + 2000);
         chk($sformatf("m_is_qh_o%0d", o), int'(bus.m_is_qh), int'(o >= 16));
         chk($sformatf("m_last_o%0d", o), int'(bus.m_last), int'(o == 31));
         @(posedge clk); #1;
         if (bus.m_ready) o++;
         cyc++;
      end
      bus.m_ready = 1'b0;
      chk("drain_count", o, 32);
      chk("busy_after_drain", int'(busy), 0);
      chk("m_valid_after_drain", int'(bus.m_valid), 0);
      chk("err_after_drain", int'(err), want_err);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_err"}, int'(err), 0);
      chk({tag, "_s_ready"}, int'(bus.s_ready), 0);
      chk({tag, "_m_valid"}, int'(bus.m_valid), 0);
      chk({tag, "_m_last"}, int'(bus.m_last), 0);
      chk({tag, "_m_is_qh"}, int'(bus.m_is_qh), 0);
      chk({tag, "_row1_r"}, feed_val(1, 1'b0), 0);
      chk({tag, "_row2_r"}, feed_val(2, 1'b0), 0);
      chk({tag, "_row1_f"}, int'(bus.core_row_in_1_f), 0);
   endtask

   // directed sequence
   initial begin
      n_vec = 0;
      n_bad = 0;
      rst = 1'b1;
      bus.s_valid = 1'b0;  bus.s_data_r = '0;  bus.s_data_i = '0;
      bus.m_ready = 1'b0;  bus.core_in_ready = 1'b0;
      set_core(0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("por");
      rst = 1'b0;
      @(posedge clk); #1;
      chk("load_entry_s_ready", int'(bus.s_ready), 1);
      chk("load_entry_busy", int'(busy), 1);

      // real-valued H, core always ready, sink always ready
      load_h(0);
      run_feed(1'b0, 22, 1'b1, 99, cyc_used);
      chk("feed_cycles_ready", cyc_used, 22);
      run_drain(1'b0, 0);

      // complex H, core ready toggling, sink pattern 1,0,0,1
      load_h(1);
      run_feed(1'b1, 22, 1'b0, 99, cyc_used);
      chk("feed_cycles_toggle", cyc_used, 44);
      run_drain(1'b1, 0);

      // stall timeout
      load_h(0);
      bus.core_in_ready = 1'b0;
      set_core(0, 1'b1);
      repeat (999) @(posedge clk);
      #1;
      chk("stall999_busy", int'(busy), 1);
      chk("stall999_err", int'(err), 0);
      chk("stall999_row1_hold", feed_val(1, 1'b0), 1);
      @(posedge clk); #1;
      chk("stall_abort_busy", int'(busy), 0);
      chk("stall_abort_err", int'(err), 1);
      chk("stall_abort_row1", feed_val(1, 1'b0), 0);
      chk("stall_abort_m_valid", int'(bus.m_valid), 0);
      @(posedge clk); #1;
      chk("reload_err_clear", int'(err), 0);
      chk("reload_s_ready", int'(bus.s_ready), 1);

      // reset in the middle of FEED at s=10
      load_h(1);
      run_feed(1'b0, 10, 1'b0, 99, cyc_used);
      rst = 1'b1;
      @(posedge clk); #1;
      chk_reset_outputs("midrst");
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_s_ready", int'(bus.s_ready), 1);
      load_h(0);
      run_feed(1'b0, 22, 1'b1, 99, cyc_used);
      run_drain(1'b0, 0);

      // core_out_valid dropped on a capture slot (step 5): err must be set
      load_h(1);
      run_feed(1'b0, 22, 1'b0, 5, cyc_used);
      run_drain(1'b0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/qrd_sched.md
Name: qrd_sched

Overview:
- Sequencer placed in front of and behind the 4x4 complex QRD systolic core.
- Accepts one H matrix as a row-major element stream and buffers it.
- Appends the identity (1.0 = 1024, 10-bit fraction) and drives the core's four skewed row inputs plus start flags, advancing only when the core reports in_ready.
- Captures the core's skewed R/QH outputs into a buffer, then streams them out deskewed and row-major.

Parameters:
- W, 14, element width (signed, two's complement) for real and imaginary parts.
- ONE, 1024, identity diagonal value appended to H.
- STALL_LIMIT, 1000, maximum consecutive core_in_ready=0 cycles in FEED before abort.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- s_valid  in  1  input element valid.
- s_ready  out  1  input element accept; a transfer is s_valid&s_ready.
- s_data_r, s_data_i  in  W  H element; order H[0][0..3], H[1][0..3], ..., H[3][3].
- m_valid  out  1  output element valid.
- m_ready  in  1  downstream accept.
- m_data_r, m_data_i  out  W  result element; R row-major (16 elements), then QH row-major (16 elements).
- m_is_qh  out  1  0 while streaming R, 1 while streaming QH.
- m_last  out  1  high on the 32nd output element.
- core_row_in_k_r, core_row_in_k_i (k=1..4)  out  W each  skewed row feed to the core.
- core_row_in_1_f, core_row_in_2_f, core_row_in_3_f  out  1 each  row start flags.
- core_in_ready  in  1  core accepts the current feed step.
- core_out_valid  in  1  core outputs valid.
- core_row_out_k_r, core_row_out_k_i (k=1..4)  in  W each  core row outputs.
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky error flag; cleared only on entry to LOAD.

Behaviour:
- Reset values:
  - State = IDLE.
  - s_ready, m_valid, m_last, m_is_qh, busy, all core_row_in_* data and flags = 0.
  - err = 0.
  - All counters = 0.
  - Buffer contents are don't-care.
- States:
  - IDLE -> LOAD unconditionally on the next cycle. On entering LOAD, err clears and s_ready goes high.
  - LOAD: the element counter e (0..15) advances per transfer and the element is written to A[e/4][e%4]. At e=15 with a transfer: s_ready drops the next cycle and the state moves to FEED with s=0.
  - FEED: step counter s runs 0..21. A step is consumed on an edge with core_in_ready=1; s increments on that edge. After step 21 is consumed, go to DRAIN with output index o=0.
  - DRAIN: m_valid=1. o (0..31) advances on m_valid&m_ready. After o=31 is transferred, return to IDLE.
- Augmented matrix A[r][c], c=0..7:
  - c<4: the loaded H.
  - c>=4: real part = ONE if c-4==r, else 0; imaginary part = 0.
- Feed values, combinational from s, registered buffer and state (zero outside FEED), for row k=1..4 with j = s-(k-1):
  - row data = A[k-1][j] if 0<=j<8, else 0.
  - core_row_in_1_f = (s==0); core_row_in_2_f = (s==2); core_row_in_3_f = (s==4).
  - Values hold unchanged while core_in_ready=0.
- Capture, performed on the edge that consumes step s, using the core outputs present during step s. For row k:
  - R[k-1][s-4-k] when 4+k<=s<=7+k.
  - QH[k-1][s-8-k] when 8+k<=s<=11+k.
  - If core_out_valid=0 at any capture slot, the element is not written and err is set.
- Stall timeout: in FEED, a counter counts consecutive core_in_ready=0 cycles. On reaching STALL_LIMIT: set err, force all core inputs to 0, go to IDLE. DRAIN is skipped.
- Output stream:
  - m_data = R[o/4][o%4] for o<16, else QH[(o-16)/4][o%4].
  - m_is_qh = (o>=16); m_last = (o==31).
  - Data holds stable while m_valid&!m_ready.
- Latency: first m_valid occurs 1 cycle after the final step is consumed. With core_in_ready and m_ready held at 1, the first output appears 22 cycles after the last input transfer.
- Reset mid-operation: returns to IDLE on the next edge, identical to power-up; any partial matrix is discarded.
- Simultaneous events: s_valid is ignored outside LOAD; core outputs are ignored outside FEED; m_ready is ignored outside DRAIN.
- Widths: pure data movement with no arithmetic; all counters saturate at their terminal state.

Test Plan:
- Load H = (r*4+c+1) + 0j, core model with in_ready=1 -> core_row_in_1_r sequence over s=0..7 is 1,2,3,4,1024,0,0,0; row 4 is 0 for s=0..2, then 13,14,15,16,0,0,0,1024; row1_f high only at s=0.
- Core model with in_ready toggling 1,0,1,0 -> each feed value is held across the 0 cycle; total FEED length is 44 cycles; the capture set is identical.
- Core model returning R[i][j]=100*i+j and QH[i][j]=-(100*i+j) on the schedule -> m stream is 0,1,2,3,100,...,303, then 0,-1,...,-303; m_is_qh rises at o=16; m_last at o=31; err=0.
- m_ready pattern 1,0,0,1 during DRAIN -> no element is dropped or duplicated; data is stable while stalled.
- core_in_ready held 0 in FEED for 1000 cycles -> err=1, state IDLE; the next LOAD entry clears err.
- rst asserted at s=10 -> all outputs are at reset values on the next edge; a following full transaction matches the golden stream.
